// File: rtl/simplecpu_pkg.sv
// Shared sizes and FSM state type for the simplecpu boot sequencer.
// Optional checksum states are present only when SIMPLECPU_BOOT_CKSUM_EN is defined.
package simplecpu_pkg;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_STOP
`ifdef SIMPLECPU_BOOT_CKSUM_EN
        ,
        ST_CHECK,
        ST_ERR
`endif
    } boot_state_e;

    function automatic logic state_is_busy(boot_state_e s);
        logic b;
        b = (s == ST_LOAD) || (s == ST_SETTLE) || (s == ST_RUN);
`ifdef SIMPLECPU_BOOT_CKSUM_EN
        b = b || (s == ST_CHECK);
`endif
        return b;
    endfunction

endpackage

// File: rtl/simplecpu_run_timer.sv
// Run-cycle budget latch and counter; expire_o marks the last allowed run cycle.
// A latched budget of 0 never expires.
module simplecpu_run_timer
    import simplecpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] budget_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] budget_q, budget_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        budget_d = budget_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            budget_d = budget_i;
            cnt_d    = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            budget_q <= '0;
            cnt_q    <= '0;
        end else begin
            budget_q <= budget_d;
            cnt_q    <= cnt_d;
        end
    end

    assign expire_o = run_i && (budget_q != '0) && (cnt_q == budget_q - CNT_W'(1));

endmodule

// File: rtl/simplecpu_boot_ctrl.sv
// Boot/run sequencer for simplecpu: loads 16 program bytes, runs the CPU for a budget, stops.
// Optional trailing-checksum verification is enabled by SIMPLECPU_BOOT_CKSUM_EN.
module simplecpu_boot_ctrl
    import simplecpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_reset,
    output logic              load_ram,
    output logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_ram_q, load_ram_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              timer_load;
    logic              timer_run;
    logic              timer_expire;
`ifdef SIMPLECPU_BOOT_CKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    simplecpu_run_timer u_run_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .run_i    (timer_run),
        .budget_i (run_cycles),
        .expire_o (timer_expire)
    );

    assign timer_load = (state_q == ST_SETTLE);
    assign timer_run  = (state_q == ST_RUN);
    // in_ready_q is only ever high in the loading states, and abort suppresses the write.
    assign accept     = in_valid && in_ready_q && !abort;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        in_ready_d  = 1'b0;
        cpu_reset_d = 1'b0;
        load_ram_d  = 1'b0;
        load_addr_d = load_addr_q;
        load_data_d = load_data_q;
        done_d      = done_q;
`ifdef SIMPLECPU_BOOT_CKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
`ifdef SIMPLECPU_BOOT_CKSUM_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_STOP
`ifdef SIMPLECPU_BOOT_CKSUM_EN
                , ST_ERR
`endif
                : begin
                    if (start) begin
                        state_d = ST_LOAD;
                        addr_d  = '0;
                        done_d  = 1'b0;
`ifdef SIMPLECPU_BOOT_CKSUM_EN
                        sum_d   = '0;
                        err_d   = 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        load_ram_d  = 1'b1;
                        load_addr_d = addr_q;
                        load_data_d = in_data;
                        addr_d      = addr_q + ADDR_W'(1);
`ifdef SIMPLECPU_BOOT_CKSUM_EN
                        sum_d       = sum_q + in_data;
                        if (addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
                            state_d = ST_CHECK;
                        end
`else
                        if (addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
                            state_d    = ST_SETTLE;
                            in_ready_d = 1'b0;
                        end
`endif
                    end
                end
`ifdef SIMPLECPU_BOOT_CKSUM_EN
                ST_CHECK: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        in_ready_d = 1'b0;
                        if (in_data == sum_q) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
`endif
                ST_SETTLE: begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b1;
                end
                ST_RUN: begin
                    cpu_reset_d = 1'b1;
                    if (timer_expire) begin
                        state_d     = ST_STOP;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = state_is_busy(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b0;
            load_ram_q  <= 1'b0;
            load_addr_q <= '0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            load_ram_q  <= load_ram_d;
            load_addr_q <= load_addr_d;
            load_data_q <= load_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SIMPLECPU_BOOT_CKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign cpu_reset = cpu_reset_q;
    assign load_ram  = load_ram_q;
    assign load_addr = load_addr_q;
    assign load_data = load_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_simplecpu_boot_ctrl.sv
// Scoreboard bench for simplecpu_boot_ctrl: expected RAM writes are queued by the stimulus
// and popped by a monitor on every load_ram pulse; run length and status checked directly.
module tb_simplecpu_boot_ctrl;
    import simplecpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  run_cycles = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              cpu_reset;
    logic              load_ram;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] prog[17];
    int unsigned       n_cmp = 0;
    int unsigned       n_bad = 0;
    int unsigned       n_wr  = 0;

    simplecpu_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .run_cycles (run_cycles),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_reset  (cpu_reset),
        .load_ram   (load_ram),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && load_ram) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                         load_addr, load_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("ram_write", {20'd0, load_addr, load_data}, {20'd0, e.a, e.d});
            end
        end
    end

    task automatic start_boot(input logic [CNT_W-1:0] budget);
        @(negedge clk);
        run_cycles = budget;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Offers prog[0..n-1]; the first min(n,16) bytes are expected as RAM writes.
    task automatic load_bytes(input int unsigned n, input bit bubble);
        int unsigned i     = 0;
        int unsigned guard = 0;
        bit          ph    = 1'b1;
        bit          acc;
        for (int unsigned k = 0; k < n && k < RAM_DEPTH; k++)
            exp_q.push_back('{a: ADDR_W'(k), d: prog[k]});
        while (i < n && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = bubble ? ph : 1'b1;
            ph       = ~ph;
            in_data  = prog[i];
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        if (i < n) check("load_timeout", i, n);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic measure_run(input int unsigned budget, input string tag);
        int unsigned w   = 0;
        int unsigned cnt = 0;
        while (cpu_reset !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        while (cpu_reset === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_run_len"}, cnt, budget);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_cpu_reset_after"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned wr0;
        int unsigned ones;

        // Reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_outputs",
                  {12'd0, in_ready, cpu_reset, load_ram, busy, done, err, load_addr, load_data},
                  32'd0);
        end

        // Back-to-back stream, budget 10
        prog[0] = 8'h51; prog[1] = 8'h80; prog[2] = 8'h90;
        for (int unsigned k = 3; k < 17; k++) prog[k] = 8'h00;
        wr0 = n_wr;
        start_boot(16'd10);
        load_bytes(16, 1'b0);
        drop_valid();
        check("busy_after_load", {31'd0, busy}, 32'd1);
        measure_run(10, "boot");
        check("boot_write_count", n_wr - wr0, 32'd16);

        // Same stream with bubbles
        wr0 = n_wr;
        start_boot(16'd10);
        check("done_cleared_by_start", {31'd0, done}, 32'd0);
        load_bytes(16, 1'b1);
        drop_valid();
        measure_run(10, "bubble");
        check("bubble_write_count", n_wr - wr0, 32'd16);

        // Abort after 7 bytes; 8th byte offered alongside abort
        start_boot(16'd10);
        load_bytes(7, 1'b0);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = prog[7];
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("abort_writes_left", exp_q.size(), 32'd0);

        // Reload from address 0 after abort, budget 3
        for (int unsigned k = 0; k < 16; k++) prog[k] = 8'(8'hA0 + k);
        start_boot(16'd3);
        load_bytes(16, 1'b0);
        drop_valid();
        measure_run(3, "reload");

        // Budget 0 runs until abort
        start_boot(16'd0);
        load_bytes(16, 1'b0);
        drop_valid();
        begin
            int unsigned w = 0;
            while (cpu_reset !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
        end
        ones = 0;
        for (int unsigned c = 0; c < 1000; c++) begin
            if (cpu_reset === 1'b1) ones++;
            @(negedge clk);
        end
        check("infinite_run_len", ones, 32'd1000);
        check("infinite_no_done", {31'd0, done}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("infinite_abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("infinite_abort_done", {31'd0, done}, 32'd0);
        check("infinite_abort_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-run drops cpu_reset immediately
        start_boot(16'd0);
        load_bytes(16, 1'b0);
        drop_valid();
        repeat (4) @(negedge clk);
        check("pre_async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_async_idle",
              {12'd0, in_ready, cpu_reset, load_ram, busy, done, err, load_addr, load_data},
              32'd0);

`ifdef SIMPLECPU_BOOT_CKSUM_EN
        // Correct checksum: 1+2+...+16 = 136 = 0x88
        for (int unsigned k = 0; k < 16; k++) prog[k] = 8'(k + 1);
        prog[16] = 8'h88;
        wr0 = n_wr;
        start_boot(16'd5);
        load_bytes(17, 1'b0);
        drop_valid();
        measure_run(5, "cksum_ok");
        check("cksum_ok_err", {31'd0, err}, 32'd0);
        check("cksum_ok_write_count", n_wr - wr0, 32'd16);

        // Wrong checksum
        prog[16] = 8'h89;
        wr0 = n_wr;
        start_boot(16'd5);
        load_bytes(17, 1'b0);
        drop_valid();
        repeat (20) @(negedge clk);
        check("cksum_bad_err", {31'd0, err}, 32'd1);
        check("cksum_bad_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("cksum_bad_busy", {31'd0, busy}, 32'd0);
        check("cksum_bad_done", {31'd0, done}, 32'd0);
        check("cksum_bad_write_count", n_wr - wr0, 32'd16);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("cksum_abort_err", {31'd0, err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
